// File: rtl/uart_rx_deserializer.sv
// UART receive front end: input synchronizer, 16x baud tick generator and a
// start/data/parity/stop frame assembler feeding a valid/ready output register.
module uart_rx_deserializer #(
  parameter int DIV_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RST_N,
  input  logic                 UART_SIN_i,
  input  logic [DIV_WIDTH-1:0] Divisor_i,
  input  logic [1:0]           Word_Len_i,
  input  logic                 Parity_En_i,
  input  logic                 Even_Parity_i,
  input  logic                 Stick_Parity_i,
  output logic [7:0]           Rx_Data_o,
  output logic                 Rx_PE_o,
  output logic                 Rx_FE_o,
  output logic                 Rx_BI_o,
  output logic                 Rx_Valid_o,
  input  logic                 Rx_Ready_i,
  output logic                 Rx_Overrun_o,
  output logic                 Rx_Busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_MARK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  state_t                 state_q, state_d;
  logic [3:0]             sc_q, sc_d;
  logic [2:0]             bc_q, bc_d;
  logic [7:0]             shreg_q, shreg_d;
  logic [1:0]             len_q, len_d;
  logic                   pen_q, pen_d, even_q, even_d, stick_q, stick_d;
  logic                   fpe_q, fpe_d, pbit_q, pbit_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_pe_q, rx_pe_d, rx_fe_q, rx_fe_d, rx_bi_q, rx_bi_d;
  logic                   rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;

  logic sin_s, tick, done, fe_new, bi_new, exp_par;
  logic [3:0] sc_inc;

  assign sin_s = sync_q[SYNC_STAGES-1];
  assign sc_inc = sc_q + 4'd1;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], UART_SIN_i};
  end

  // Compare with >= so a divisor lowered below the running count still wraps promptly.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (Divisor_i == '0) begin
      cnt_d = '0;
    end else if (cnt_q >= Divisor_i - DIV_WIDTH'(1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    bc_d    = bc_q;
    shreg_d = shreg_q;
    len_d   = len_q;
    pen_d   = pen_q;
    even_d  = even_q;
    stick_d = stick_q;
    fpe_d   = fpe_q;
    pbit_d  = pbit_q;
    done    = 1'b0;
    fe_new  = 1'b0;
    bi_new  = 1'b0;
    exp_par = stick_q ? ~even_q : (^shreg_q) ^ even_q ^ 1'b1;
    if (tick) begin
      case (state_q)
        S_IDLE: begin
          if (!sin_s) begin
            state_d = S_START;
            sc_d    = '0;
            bc_d    = '0;
            shreg_d = '0;
            fpe_d   = 1'b0;
            pbit_d  = 1'b0;
            len_d   = Word_Len_i;
            pen_d   = Parity_En_i;
            even_d  = Even_Parity_i;
            stick_d = Stick_Parity_i;
          end
        end
        S_START: begin
          if (sc_q == 4'd7) begin
            state_d = sin_s ? S_IDLE : S_DATA;
            sc_d    = '0;
          end else begin
            sc_d = sc_inc;
          end
        end
        S_DATA: begin
          sc_d = sc_inc;
          if (sc_q == 4'd15) begin
            shreg_d[bc_q] = sin_s;
            bc_d          = bc_q + 3'd1;
            if (bc_q == 3'd4 + {1'b0, len_q}) begin
              state_d = pen_q ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          sc_d = sc_inc;
          if (sc_q == 4'd15) begin
            pbit_d  = sin_s;
            fpe_d   = sin_s ^ exp_par;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          sc_d = sc_inc;
          if (sc_q == 4'd15) begin
            done    = 1'b1;
            fe_new  = ~sin_s;
            bi_new  = (shreg_q == 8'd0) && !(pen_q && pbit_q) && !sin_s;
            state_d = sin_s ? S_IDLE : S_WAIT_MARK;
          end
        end
        S_WAIT_MARK: begin
          if (sin_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // A completed frame is only taken if the holding register is empty or draining this cycle.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_pe_d    = rx_pe_q;
    rx_fe_d    = rx_fe_q;
    rx_bi_d    = rx_bi_q;
    rx_valid_d = rx_valid_q;
    rx_ovr_d   = 1'b0;
    if (rx_valid_q && Rx_Ready_i) rx_valid_d = 1'b0;
    if (done) begin
      if (!rx_valid_q || Rx_Ready_i) begin
        rx_data_d  = shreg_q;
        rx_pe_d    = fpe_q;
        rx_fe_d    = fe_new;
        rx_bi_d    = bi_new;
        rx_valid_d = 1'b1;
      end else begin
        rx_ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge WB_CLK or negedge WB_RST_N) begin
    if (!WB_RST_N) begin
      sync_q     <= '1;
      cnt_q      <= '0;
      state_q    <= S_IDLE;
      sc_q       <= '0;
      bc_q       <= '0;
      shreg_q    <= '0;
      len_q      <= '0;
      pen_q      <= 1'b0;
      even_q     <= 1'b0;
      stick_q    <= 1'b0;
      fpe_q      <= 1'b0;
      pbit_q     <= 1'b0;
      rx_data_q  <= '0;
      rx_pe_q    <= 1'b0;
      rx_fe_q    <= 1'b0;
      rx_bi_q    <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      sc_q       <= sc_d;
      bc_q       <= bc_d;
      shreg_q    <= shreg_d;
      len_q      <= len_d;
      pen_q      <= pen_d;
      even_q     <= even_d;
      stick_q    <= stick_d;
      fpe_q      <= fpe_d;
      pbit_q     <= pbit_d;
      rx_data_q  <= rx_data_d;
      rx_pe_q    <= rx_pe_d;
      rx_fe_q    <= rx_fe_d;
      rx_bi_q    <= rx_bi_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
    end
  end

  assign Rx_Data_o    = rx_data_q;
  assign Rx_PE_o      = rx_pe_q;
  assign Rx_FE_o      = rx_fe_q;
  assign Rx_BI_o      = rx_bi_q;
  assign Rx_Valid_o   = rx_valid_q;
  assign Rx_Overrun_o = rx_ovr_q;
  assign Rx_Busy_o    = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboard bench for uart_rx_deserializer: serial frames are driven on the pin,
// expected characters come from a frame-level reference model.
module tb_uart_rx_deserializer;

  logic        WB_CLK = 1'b0;
  logic        WB_RST_N = 1'b0;
  logic        UART_SIN_i = 1'b1;
  logic [15:0] Divisor_i = 16'd1;
  logic [1:0]  Word_Len_i = 2'd3;
  logic        Parity_En_i = 1'b0;
  logic        Even_Parity_i = 1'b0;
  logic        Stick_Parity_i = 1'b0;
  logic [7:0]  Rx_Data_o;
  logic        Rx_PE_o, Rx_FE_o, Rx_BI_o, Rx_Valid_o, Rx_Overrun_o, Rx_Busy_o;
  logic        Rx_Ready_i = 1'b0;

  uart_rx_deserializer #(.DIV_WIDTH(16), .SYNC_STAGES(2)) dut (
    .WB_CLK(WB_CLK), .WB_RST_N(WB_RST_N), .UART_SIN_i(UART_SIN_i),
    .Divisor_i(Divisor_i), .Word_Len_i(Word_Len_i), .Parity_En_i(Parity_En_i),
    .Even_Parity_i(Even_Parity_i), .Stick_Parity_i(Stick_Parity_i),
    .Rx_Data_o(Rx_Data_o), .Rx_PE_o(Rx_PE_o), .Rx_FE_o(Rx_FE_o), .Rx_BI_o(Rx_BI_o),
    .Rx_Valid_o(Rx_Valid_o), .Rx_Ready_i(Rx_Ready_i), .Rx_Overrun_o(Rx_Overrun_o),
    .Rx_Busy_o(Rx_Busy_o)
  );

  always #5 WB_CLK = ~WB_CLK;

  int          n_vec = 0;
  int          n_err = 0;
  int          ovr_cnt = 0;
  logic [10:0] sb[$];
  bit          ready_rand = 1'b0;
  bit          ready_man = 1'b1;
  logic [1:0]  cfg_len = 2'd3;
  bit          cfg_pen = 1'b0, cfg_even = 1'b0, cfg_stick = 1'b0;
  int          cfg_div = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Expected {data, PE, FE, BI} for one frame from the bits put on the line.
  function automatic logic [10:0] model(input logic [7:0] d, input int nb, input bit pen,
                                        input bit even, input bit stick, input bit pbit,
                                        input bit stop);
    logic [7:0] dm;
    int ones;
    bit exp_p, pe, fe, bi;
    dm = d & 8'((1 << nb) - 1);
    ones = $countones(dm);
    if (stick)     exp_p = !even;
    else if (even) exp_p = (ones % 2 == 1);
    else           exp_p = (ones % 2 == 0);
    pe = pen && (pbit != exp_p);
    fe = !stop;
    bi = (dm == 8'd0) && !(pen && pbit) && !stop;
    return {dm, pe, fe, bi};
  endfunction

  task automatic drive_bit(input logic b, input int n);
    UART_SIN_i = b;
    repeat (n) @(negedge WB_CLK);
  endtask

  // Call at a falling edge; returns at a falling edge with the line idle.
  task automatic send_frame(input logic [7:0] d, input bit pbit, input bit stop,
                            input bit push, input bit scramble);
    int nb;
    int per;
    nb = 5 + int'(cfg_len);
    per = 16 * cfg_div;
    Divisor_i = 16'(cfg_div);
    Word_Len_i = cfg_len;
    Parity_En_i = cfg_pen;
    Even_Parity_i = cfg_even;
    Stick_Parity_i = cfg_stick;
    if (push) sb.push_back(model(d, nb, cfg_pen, cfg_even, cfg_stick, pbit, stop));
    drive_bit(1'b0, per);
    if (scramble) begin
      Word_Len_i = 2'($urandom_range(0, 3));
      Parity_En_i = 1'($urandom_range(0, 1));
      Even_Parity_i = 1'($urandom_range(0, 1));
      Stick_Parity_i = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < nb; i++) drive_bit(d[i], per);
    Word_Len_i = cfg_len;
    Parity_En_i = cfg_pen;
    Even_Parity_i = cfg_even;
    Stick_Parity_i = cfg_stick;
    if (cfg_pen) drive_bit(pbit, per);
    drive_bit(stop, per);
    UART_SIN_i = 1'b1;
  endtask

  task automatic wait_busy(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge WB_CLK);
      seen = Rx_Busy_o;
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    forever begin
      @(negedge WB_CLK);
      #1;
      Rx_Ready_i = ready_rand ? 1'($urandom_range(0, 1)) : ready_man;
    end
  end

  // Monitor: every accepted character is checked against the scoreboard head.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge WB_CLK);
      #2;
      if (WB_RST_N) begin
        if (Rx_Overrun_o) ovr_cnt++;
        if (Rx_Valid_o && Rx_Ready_i) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_char: got %0h, expected no character", Rx_Data_o);
          end else begin
            e = sb.pop_front();
            chk("rx_char{data,pe,fe,bi}", 32'({Rx_Data_o, Rx_PE_o, Rx_FE_o, Rx_BI_o}), 32'(e));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap;
    bit act;
    logic [7:0] v;
    logic [7:0] d;
    bit pb, st;

    repeat (3) @(negedge WB_CLK);
    chk("rst_data", 32'(Rx_Data_o), 32'd0);
    chk("rst_valid", 32'(Rx_Valid_o), 32'd0);
    chk("rst_busy", 32'(Rx_Busy_o), 32'd0);
    chk("rst_flags", 32'({Rx_PE_o, Rx_FE_o, Rx_BI_o, Rx_Overrun_o}), 32'd0);
    WB_RST_N = 1'b1;
    repeat (5) @(negedge WB_CLK);

    // 8N1 latency with ready held high
    cfg_div = 1; cfg_len = 2'd3; cfg_pen = 0; cfg_even = 0; cfg_stick = 0;
    ready_man = 1'b1;
    fork
      send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        int k;
        bit seen;
        wait_busy("a5_busy_start");
        k = 0;
        seen = 1'b0;
        while (!seen && k < 400) begin
          @(negedge WB_CLK);
          k++;
          seen = Rx_Valid_o;
        end
        chk("a5_latency_ticks", 32'(k), 32'd152);
        @(negedge WB_CLK);
        chk("a5_valid_one_cycle", 32'(Rx_Valid_o), 32'd0);
      end
    join
    repeat (20) @(negedge WB_CLK);

    // Start-bit glitch of 5 ticks at divisor 3
    cfg_div = 3;
    Divisor_i = 16'd3;
    repeat (10) @(negedge WB_CLK);
    UART_SIN_i = 1'b0;
    repeat (15) @(negedge WB_CLK);
    chk("glitch_busy_entered", 32'(Rx_Busy_o), 32'd1);
    UART_SIN_i = 1'b1;
    repeat (48) @(negedge WB_CLK);
    chk("glitch_rejected_idle", 32'(Rx_Busy_o), 32'd0);

    // 7E1 wrong parity, then stick parity
    cfg_div = 1; cfg_len = 2'd2; cfg_pen = 1; cfg_even = 1; cfg_stick = 0;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge WB_CLK);
    cfg_even = 0; cfg_stick = 1;
    send_frame(8'h41, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge WB_CLK);

    // Break for three 8N1 frame times, then a normal character
    cfg_len = 2'd3; cfg_pen = 0; cfg_even = 0; cfg_stick = 0;
    Word_Len_i = cfg_len; Parity_En_i = 0; Even_Parity_i = 0; Stick_Parity_i = 0;
    sb.push_back(model(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    drive_bit(1'b0, 480);
    drive_bit(1'b1, 40);
    chk("break_single_char", 32'(sb.size()), 32'd0);
    send_frame(8'h55, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge WB_CLK);

    // Overrun, then completion coinciding with a transfer
    ready_man = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (10) @(negedge WB_CLK);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge WB_CLK);
    chk("overrun_pulse_count", 32'(ovr_cnt), 32'd1);
    chk("overrun_held_data", 32'(Rx_Data_o), 32'h11);
    chk("overrun_held_valid", 32'(Rx_Valid_o), 32'd1);
    fork
      send_frame(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
      begin
        wait_busy("c33_busy_start");
        repeat (151) @(negedge WB_CLK);
        ready_man = 1'b1;
      end
    join
    repeat (10) @(negedge WB_CLK);
    chk("no_overrun_on_transfer", 32'(ovr_cnt), 32'd1);
    chk("queue_after_33", 32'(sb.size()), 32'd0);

    // Reset in the middle of a frame
    v = 8'hC3;
    UART_SIN_i = 1'b0;
    repeat (16) @(negedge WB_CLK);
    for (int i = 0; i < 4; i++) drive_bit(v[i], 16);
    WB_RST_N = 1'b0;
    #1;
    chk("midframe_rst_busy", 32'(Rx_Busy_o), 32'd0);
    chk("midframe_rst_valid", 32'(Rx_Valid_o), 32'd0);
    UART_SIN_i = 1'b1;
    repeat (3) @(negedge WB_CLK);
    WB_RST_N = 1'b1;
    repeat (20) @(negedge WB_CLK);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (20) @(negedge WB_CLK);

    // Divisor 0 freezes reception
    Divisor_i = 16'd0;
    act = 1'b0;
    for (int i = 0; i < 200; i++) begin
      UART_SIN_i = 1'($urandom_range(0, 1));
      @(negedge WB_CLK);
      act = act | Rx_Busy_o | Rx_Valid_o;
    end
    chk("div0_no_activity", 32'(act), 32'd0);
    UART_SIN_i = 1'b1;
    repeat (5) @(negedge WB_CLK);
    Divisor_i = 16'd1;
    repeat (10) @(negedge WB_CLK);
    chk("div0_restore_idle", 32'(Rx_Busy_o), 32'd0);

    // Randomized frames with random config, random backpressure
    ready_rand = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cfg_div = int'($urandom_range(1, 3));
      cfg_len = 2'($urandom_range(0, 3));
      cfg_pen = 1'($urandom_range(0, 1));
      cfg_even = 1'($urandom_range(0, 1));
      cfg_stick = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 5) == 0) d = 8'h00;
      pb = 1'($urandom_range(0, 1));
      st = ($urandom_range(0, 7) != 0);
      send_frame(d, pb, st, 1'b1, 1'(k % 2));
      gap = (6 + int'($urandom_range(0, 16))) * cfg_div;
      repeat (gap) @(negedge WB_CLK);
    end
    ready_rand = 1'b0;
    ready_man = 1'b1;
    repeat (100) @(negedge WB_CLK);
    chk("queue_drained", 32'(sb.size()), 32'd0);
    chk("overrun_total", 32'(ovr_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
Receive-side front end for the FPGA UART 16550 path. It synchronizes the raw UART0 serial input pin, generates a 16x oversampling tick from a programmable divisor, and assembles one asynchronous frame at a time: start bit, 5-8 data bits, optional parity, and stop bit. It presents each received character with its error flags to the downstream RX FIFO and line-status logic through a valid/ready handshake.

Parameters:
DIV_WIDTH, 16, width of the baud divisor input
SYNC_STAGES, 2, number of input synchronizer flops (minimum 2)

Ports:
WB_CLK  input  1  system clock; all logic on rising edge
WB_RST_N  input  1  reset, asynchronous assert, active-low
UART_SIN_i  input  1  raw serial input, idle high
Divisor_i  input  DIV_WIDTH  16x-tick period in WB_CLK cycles; 0 disables reception
Word_Len_i  input  2  data bits minus 5 (00=5 … 11=8)
Parity_En_i  input  1  parity bit present
Even_Parity_i  input  1  even parity select
Stick_Parity_i  input  1  stick parity select
Rx_Data_o  output  8  received character, LSB-aligned; unused upper bits 0
Rx_PE_o  output  1  parity error for Rx_Data_o
Rx_FE_o  output  1  framing error (stop bit sampled 0)
Rx_BI_o  output  1  break indication
Rx_Valid_o  output  1  Rx_Data_o and flags valid
Rx_Ready_i  input  1  consumer accepts when Rx_Valid_o=1
Rx_Overrun_o  output  1  one-cycle pulse; completed frame discarded
Rx_Busy_o  output  1  frame in progress (state not IDLE)

Behaviour:
- Reset: synchronizer flops=1; baud counter=0; state=IDLE; Rx_Data_o=0; Rx_PE_o, Rx_FE_o, Rx_BI_o, Rx_Valid_o, Rx_Overrun_o, Rx_Busy_o=0. A reset mid-frame discards the partial frame.
- Synchronizer: SYNC_STAGES flops; sin_s is the last stage. All sampling uses sin_s.
- Tick generator: counter increments each cycle. tick=1 when cnt==Divisor_i-1, and cnt then returns to 0. Divisor_i=1 gives a tick every cycle. Divisor_i=0 holds cnt at 0, gives no ticks, and freezes the FSM.
- The FSM advances only on tick cycles. A sub-bit counter sc (4 bits) counts ticks within a bit.
- IDLE: on a tick with sin_s=0, go to START with sc=0. Latch Word_Len_i, Parity_En_i, Even_Parity_i and Stick_Parity_i. Configuration changes mid-frame do not affect the frame in progress.
- START: when sc==7 (mid-bit), if sin_s=0 go to DATA with sc=0; otherwise return to IDLE (glitch rejected, no output).
- DATA: sample when sc==15. Shift bits in LSB first. After 5+len bits go to PARITY if enabled, else STOP.
- PARITY: sample when sc==15.
  - Expected bit: stick=1 gives ~even; stick=0 gives XOR(data)^even^1 (odd: data+parity has odd ones).
  - PE=1 on mismatch.
- STOP: sample when sc==15.
  - FE=~sin_s.
  - BI=1 when data bits, parity bit (if present) and stop bit are all 0.
  - Go to IDLE if sin_s=1, else to WAIT_MARK.
- WAIT_MARK: stay until a tick with sin_s=1, then go to IDLE. A break produces exactly one character.
- Output register: loads on the cycle after the stop-sample tick (Rx_Valid_o rises then). The frame result is Rx_Data_o, Rx_PE_o, Rx_FE_o and Rx_BI_o.
- Handshake: transfer occurs when Rx_Valid_o & Rx_Ready_i. On transfer, Rx_Valid_o clears next cycle unless a new frame loads in the same cycle.
- Frame completes while Rx_Valid_o=1 and Rx_Ready_i=0: held data is kept, the new frame is dropped, and Rx_Overrun_o pulses for one cycle.
- Frame completes in the same cycle as a transfer: the new frame loads, Rx_Valid_o stays 1, no overrun.
- Rx_Busy_o=1 in every state except IDLE.

Test Plan:
- 8N1, Divisor_i=1, send 0xA5 → Rx_Data_o=0xA5, PE=FE=BI=0, Rx_Valid_o rises 1+7+8*16+16 ticks after the start edge reaches sin_s. Hold Rx_Ready_i=1 → valid for one cycle.
- 8N1, Divisor_i=3, low glitch of 5 ticks on an idle line → no Rx_Valid_o, FSM back to IDLE, Rx_Busy_o low after 8 ticks.
- 7E1, send 0x41 with parity bit 1 (wrong) → Rx_Data_o=0x41, PE=1. Repeat with stick=1, even=0, parity bit 1 → PE=0.
- Line held low for 3 frame times (8N1), then high → exactly one character: Rx_Data_o=0x00, FE=1, BI=1. Next frame 0x55 received normally.
- Rx_Ready_i=0, send 0x11 then 0x22 → Rx_Data_o stays 0x11, one-cycle Rx_Overrun_o at 0x22's completion. Then assert Rx_Ready_i while 0x33 completes in the same cycle → 0x33 loaded, no overrun.
- Assert WB_RST_N low mid-data of 0xC3, release, send 0x3C → only 0x3C delivered. Divisor_i=0 with line toggling → no activity, counter held at 0.
